fx_accumulator: RTL and testbench

- Downstream stage of the fixed-point multiplier. Consumes a stream of registered products in S,10.21 format (1 sign bit, 10 integer bits, 21 fraction bits; two's complement).
- Accumulates a programmed number of terms with saturating addition.
- Presents the final sum on a valid/ready output handshake.
- Used for dot products and series evaluation in the accelerator datapath.

---
 rtl/fx_accumulator_pkg.sv | 13 +
 rtl/fx_accumulator_if.sv | 30 +++
 rtl/fx_sat_add.sv | 22 ++
 rtl/fx_accumulator.sv | 71 +++++++
 tb/tb_fx_accumulator.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fx_accumulator_pkg.sv
// Shared constants and types for the fixed-point accumulator datapath.
package fx_pkg;
   localparam int          FX_WIDTH = 32;
   localparam int          FX_FRAC  = 21;
   localparam logic [31:0] FX_MAX   = 32'h7FFF_FFFF;
   localparam logic [31:0] FX_MIN   = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_t;
endpackage

// File: rtl/fx_accumulator_if.sv
// Control, term-stream and result handshake of the accumulator.
interface fx_accumulator_if
   import fx_pkg::*;
#(
   parameter int WIDTH = FX_WIDTH,
   parameter int CNT_W = 16
);
   logic             start;
   logic [CNT_W-1:0] num_terms;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic             overflow;
   logic             busy;

   // Producer / consumer side.
   modport master (
      output start, num_terms, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, overflow, busy
   );

   // Accumulator side.
   modport slave (
      input  start, num_terms, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, overflow, busy
   );
endinterface

// File: rtl/fx_sat_add.sv
// Combinational two's-complement saturating adder with clamp flag.
module fx_sat_add #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             sat
);
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH:0] ext;

   // One guard bit: top two bits disagree exactly when the true sum is out of range.
   always_comb begin
      ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      sat = ext[WIDTH] ^ ext[WIDTH-1];
      sum = ext[WIDTH-1:0];
      if (sat) sum = ext[WIDTH] ? SMIN : SMAX;
   end
endmodule

// File: rtl/fx_accumulator.sv
// Saturating accumulator over a programmed number of S,10.21 terms.
module fx_accumulator
   import fx_pkg::*;
#(
   parameter int WIDTH = FX_WIDTH,
   parameter int CNT_W = 16
) (
   input logic              clk,
   input logic              rst,
   fx_accumulator_if.slave  bus
);
   acc_state_t       state;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] count;
   logic             ovf;
   logic [WIDTH-1:0] sum;
   logic             sat;
   logic             accept;

   fx_sat_add #(.WIDTH(WIDTH)) u_add (
      .a   (acc),
      .b   (bus.in_data),
      .sum (sum),
      .sat (sat)
   );

   assign accept        = (state == ACCUM) && bus.in_valid;
   assign bus.in_ready  = (state == ACCUM);
   assign bus.out_valid = (state == DONE);
   // acc doubles as the result register so it survives the return to IDLE.
   assign bus.out_data  = acc;
   assign bus.overflow  = ovf;
   assign bus.busy      = (state != IDLE);

   // Control FSM plus accumulator/counter update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  acc <= '0;
                  ovf <= 1'b0;
                  if (bus.num_terms == '0) begin
                     state <= DONE;
                  end else begin
                     count <= bus.num_terms;
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc   <= sum;
                  count <= count - 1'b1;
                  if (sat) ovf <= 1'b1;
                  if (count == CNT_W'(1)) state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fx_accumulator.sv
// Directed self-checking bench for fx_accumulator.
module tb_fx_accumulator;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fx_accumulator_if #(.WIDTH(32), .CNT_W(16)) bus ();

   fx_accumulator #(.WIDTH(32), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] n);
      bus.start     = 1'b1;
      bus.num_terms = n;
      tick();
      bus.start     = 1'b0;
   endtask

   task automatic feed(input logic [31:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.overflow, bus.busy} !== 4'b0000 || bus.out_data !== 32'h0) begin
         errors++;
         $display("FAIL reset: rdy/vld/ovf/busy=%b data=%h want 0000/0", {bus.in_ready, bus.out_valid, bus.overflow, bus.busy}, bus.out_data);
      end
   endtask

   task automatic test_basic();
      do_start(16'd3);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_accum_state: in_ready=%b busy=%b want 1 1", bus.in_ready, bus.busy);
      end
      bus.in_valid = 1'b1;
      bus.in_data = 32'h0030_0000; tick();
      bus.in_data = 32'h0048_0000; tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_early_valid: out_valid=%b want 0", bus.out_valid);
      end
      bus.in_data = 32'h0020_0000; tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0098_0000 || bus.overflow !== 1'b0 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_sum: vld=%b data=%h ovf=%b rdy=%b want 1 00980000 0 0", bus.out_valid, bus.out_data, bus.overflow, bus.in_ready);
      end
      drain();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 32'h0098_0000) begin
         errors++;
         $display("FAIL basic_idle_hold: vld=%b busy=%b data=%h want 0 0 00980000", bus.out_valid, bus.busy, bus.out_data);
      end
   endtask

   task automatic test_gapped();
      do_start(16'd2);
      feed(32'hFFE0_0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_hold[%0d]: in_ready=%b out_valid=%b want 1 0", i, bus.in_ready, bus.out_valid);
         end
      end
      feed(32'h0010_0000);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFF0_0000 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL gap_sum: vld=%b data=%h ovf=%b want 1 fff00000 0", bus.out_valid, bus.out_data, bus.overflow);
      end
      drain();
   endtask

   task automatic test_saturation();
      do_start(16'd3);
      feed(32'h7FF0_0000);
      checks++;
      if (bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL sat_pre: overflow=%b want 0", bus.overflow);
      end
      feed(32'h0020_0000);
      checks++;
      if (bus.overflow !== 1'b1) begin
         errors++;
         $display("FAIL sat_flag: overflow=%b want 1", bus.overflow);
      end
      feed(32'hFFE0_0000);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h7FDF_FFFF || bus.overflow !== 1'b1) begin
         errors++;
         $display("FAIL sat_sum: vld=%b data=%h ovf=%b want 1 7fdfffff 1", bus.out_valid, bus.out_data, bus.overflow);
      end
      drain();
      checks++;
      if (bus.overflow !== 1'b1 || bus.out_data !== 32'h7FDF_FFFF) begin
         errors++;
         $display("FAIL sat_sticky_idle: ovf=%b data=%h want 1 7fdfffff", bus.overflow, bus.out_data);
      end
   endtask

   task automatic test_zero_backpressure();
      do_start(16'd0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL zero_done: vld=%b data=%h ovf=%b want 1 0 0", bus.out_valid, bus.out_data, bus.overflow);
      end
      for (int i = 0; i < 5; i++) begin
         bus.start     = i[0];
         bus.num_terms = 16'd2;
         tick();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_stall[%0d]: vld=%b data=%h busy=%b rdy=%b want 1 0 1 0", i, bus.out_valid, bus.out_data, bus.busy, bus.in_ready);
         end
      end
      // start coincident with DONE->IDLE must be dropped
      bus.start     = 1'b1;
      bus.num_terms = 16'd5;
      drain();
      bus.start     = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_release: busy=%b vld=%b want 0 0", bus.busy, bus.out_valid);
      end
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL start_on_exit_ignored: busy=%b rdy=%b want 0 0", bus.busy, bus.in_ready);
      end
   endtask

   task automatic test_reset_mid();
      do_start(16'd4);
      feed(32'h0030_0000);
      feed(32'h0030_0000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.overflow, bus.busy} !== 4'b0000 || bus.out_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid: rdy/vld/ovf/busy=%b data=%h want 0000/0", {bus.in_ready, bus.out_valid, bus.overflow, bus.busy}, bus.out_data);
      end
      do_start(16'd1);
      feed(32'h0020_0000);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0020_0000) begin
         errors++;
         $display("FAIL reset_fresh: vld=%b data=%h want 1 00200000", bus.out_valid, bus.out_data);
      end
      drain();
   endtask

   task automatic test_neg_saturation();
      do_start(16'd2);
      feed(32'h8010_0000);
      feed(32'hFFC0_0000);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h8000_0000 || bus.overflow !== 1'b1) begin
         errors++;
         $display("FAIL neg_sat: vld=%b data=%h ovf=%b want 1 80000000 1", bus.out_valid, bus.out_data, bus.overflow);
      end
      drain();
   endtask

   task automatic test_max_count();
      do_start(16'hFFFF);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0000_0001;
      for (int i = 0; i < 65534; i++) tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL max_count_early: vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_FFFF || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL max_count_sum: vld=%b data=%h ovf=%b want 1 0000ffff 0", bus.out_valid, bus.out_data, bus.overflow);
      end
      drain();
   endtask

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.num_terms = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_gapped();
      test_saturation();
      test_zero_backpressure();
      test_reset_mid();
      test_neg_saturation();
      test_max_count();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
